// File: rtl/val_debounce.sv
// Per-channel switch debouncer: two-flop synchronizer, per-bit qualification counter,
// registered debounced level plus change/rise strobes.
module val_debounce #(
  parameter int               WIDTH         = 4,
  parameter int               STABLE_CYCLES = 16,   // legal range 2..65535
  parameter logic [WIDTH-1:0] INIT_VAL      = '0
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic [WIDTH-1:0] sw,
  input  logic             enable,
  output logic [WIDTH-1:0] val,
  output logic             changed,
  output logic [WIDTH-1:0] rise
);

  localparam int             CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] mismatch;
  logic [WIDTH-1:0] flip;

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    mismatch = s2 ^ val;
    flip     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip[i] = enable && mismatch[i] && (cnt[i] == CNT_MAX);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      s1 <= INIT_VAL;
      s2 <= INIT_VAL;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  // Counters only advance while the synchronized level disagrees with val; the
  // terminal count flips val and clears, so the count can never wrap.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      // NOTE: cnt is a bank of independent registers, not a RAM, so every entry
      // is reset; a partial qualification must not survive reset.
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!enable || !mismatch[i] || flip[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Strobes are registered alongside val so they describe the edge that updated it.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      val     <= INIT_VAL;
      changed <= 1'b0;
      rise    <= '0;
    end else begin
      val     <= val ^ flip;
      changed <= |flip;
      rise    <= flip & s2;
    end
  end

endmodule

// File: tb/tb_val_debounce.sv
// Directed and model-checked bench for val_debounce with WIDTH=4, STABLE_CYCLES=4,
// INIT_VAL=0.
module tb_val_debounce;

  localparam int WIDTH = 4;
  localparam int SC    = 4;

  logic             clk;
  logic             rst_x;
  logic [WIDTH-1:0] sw;
  logic             enable;
  logic [WIDTH-1:0] val;
  logic             changed;
  logic [WIDTH-1:0] rise;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state for the randomized phase.
  logic [WIDTH-1:0] m_s1, m_s2, m_val, m_rise;
  logic             m_chg;
  int               m_cnt [WIDTH];

  val_debounce #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(SC),
    .INIT_VAL     (4'b0000)
  ) dut (
    .clk    (clk),
    .rst_x  (rst_x),
    .sw     (sw),
    .enable (enable),
    .val    (val),
    .changed(changed),
    .rise   (rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has already driven sw to the new level with s2 == old_v and all counts at 0.
  task automatic qualify(input logic [WIDTH-1:0] old_v, input logic [WIDTH-1:0] new_v,
                         input logic [WIDTH-1:0] exp_rise, input string tag);
    for (int k = 1; k <= SC + 3; k++) begin
      tick();
      if (k < SC + 2) begin
        check({tag, "_val_hold"}, val, old_v);
        check({tag, "_chg_idle"}, {3'b000, changed}, 4'b0000);
      end else if (k == SC + 2) begin
        check({tag, "_val_flip"}, val, new_v);
        check({tag, "_chg_pulse"}, {3'b000, changed}, 4'b0001);
        check({tag, "_rise"}, rise, exp_rise);
      end else begin
        check({tag, "_val_after"}, val, new_v);
        check({tag, "_chg_after"}, {3'b000, changed}, 4'b0000);
        check({tag, "_rise_after"}, rise, 4'b0000);
      end
    end
  endtask

  task automatic model_step();
    logic [WIDTH-1:0] nv;
    nv     = m_val;
    m_rise = '0;
    m_chg  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!enable || (m_s2[i] == m_val[i])) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] == SC - 1) begin
        nv[i]     = ~m_val[i];
        m_chg     = 1'b1;
        m_rise[i] = m_s2[i];
        m_cnt[i]  = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_val = nv;
    m_s2  = m_s1;
    m_s1  = sw;
  endtask

  initial begin
    logic [7:0]       pat;
    logic [WIDTH-1:0] mask;
    int               pulses;

    rst_x  = 1'b0;
    sw     = 4'b0000;
    enable = 1'b1;
    #2;
    check("reset_val", val, 4'b0000);
    check("reset_chg", {3'b000, changed}, 4'b0000);
    check("reset_rise", rise, 4'b0000);

    // Single rising bit: visible on edge 6 after release.
    tick();
    rst_x = 1'b1;
    sw    = 4'b0001;
    qualify(4'b0000, 4'b0001, 4'b0001, "rise0");

    // Falling bit produces CHANGED without RISE.
    sw = 4'b0000;
    qualify(4'b0001, 4'b0000, 4'b0000, "fall0");

    // Bounce 1,1,1,0,1,1,1,1 on bit 0; the glitch restarts qualification.
    pat    = 8'b1111_0111;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      sw = (k <= 8) ? {3'b000, pat[k-1]} : 4'b0001;
      tick();
      check("bounce_val", val, (k >= 10) ? 4'b0001 : 4'b0000);
      check("bounce_chg", {3'b000, changed}, (k == 10) ? 4'b0001 : 4'b0000);
      if (changed) pulses++;
    end
    check("bounce_pulses", WIDTH'(pulses), 4'b0001);

    sw = 4'b0000;
    qualify(4'b0001, 4'b0000, 4'b0000, "fall1");

    // Two bits rising together, then falling together.
    sw = 4'b1010;
    qualify(4'b0000, 4'b1010, 4'b1010, "multi_rise");
    sw = 4'b0000;
    qualify(4'b1010, 4'b0000, 4'b0000, "multi_fall");

    // Bits 0 and 1 offset by one cycle: CHANGED on two consecutive cycles.
    sw = 4'b0001;
    tick();
    sw = 4'b0011;
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (k < 6) begin
        check("b2b_val_hold", val, 4'b0000);
        check("b2b_chg_idle", {3'b000, changed}, 4'b0000);
      end else if (k == 6) begin
        check("b2b_val_first", val, 4'b0001);
        check("b2b_chg_first", {3'b000, changed}, 4'b0001);
        check("b2b_rise_first", rise, 4'b0001);
      end else if (k == 7) begin
        check("b2b_val_second", val, 4'b0011);
        check("b2b_chg_second", {3'b000, changed}, 4'b0001);
        check("b2b_rise_second", rise, 4'b0010);
      end else begin
        check("b2b_chg_after", {3'b000, changed}, 4'b0000);
      end
    end
    sw = 4'b0000;
    qualify(4'b0011, 4'b0000, 4'b0000, "b2b_fall");

    // ENABLE low freezes val for 20 cycles; after raising it a full 4-edge count is needed.
    enable = 1'b0;
    sw     = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("dis_val", val, 4'b0000);
      check("dis_chg", {3'b000, changed}, 4'b0000);
    end
    enable = 1'b1;
    for (int k = 1; k <= SC; k++) begin
      tick();
      if (k < SC) begin
        check("en_val_hold", val, 4'b0000);
      end else begin
        check("en_val_flip", val, 4'b1111);
        check("en_chg", {3'b000, changed}, 4'b0001);
        check("en_rise", rise, 4'b1111);
      end
    end
    sw = 4'b0000;
    qualify(4'b1111, 4'b0000, 4'b0000, "en_fall");

    // Reset mid-qualification (cnt=2), asserted between edges.
    sw = 4'b1111;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("pre_rst_val", val, 4'b0000);
    end
    #3;
    rst_x = 1'b0;
    #1;
    check("rst_mid_val", val, 4'b0000);
    check("rst_mid_chg", {3'b000, changed}, 4'b0000);
    tick();
    check("rst_held_val", val, 4'b0000);
    rst_x = 1'b1;
    qualify(4'b0000, 4'b1111, 4'b1111, "post_rst");

    // Async reset clears a nonzero val before any clock edge.
    #3;
    rst_x = 1'b0;
    #1;
    check("rst_async_val", val, 4'b0000);
    check("rst_async_chg", {3'b000, changed}, 4'b0000);
    check("rst_async_rise", rise, 4'b0000);
    sw = 4'b0000;
    #2;
    rst_x  = 1'b1;
    m_s1   = '0;
    m_s2   = '0;
    m_val  = '0;
    m_rise = '0;
    m_chg  = 1'b0;
    for (int i = 0; i < WIDTH; i++) m_cnt[i] = 0;

    // Random bounce against the reference model.
    for (int c = 0; c < 2000; c++) begin
      mask = '0;
      for (int b = 0; b < WIDTH; b++) mask[b] = ($urandom_range(4) == 0);
      sw     = sw ^ mask;
      enable = ($urandom_range(31) != 0);
      model_step();
      tick();
      check("rnd_val", val, m_val);
      check("rnd_chg", {3'b000, changed}, {3'b000, m_chg});
      check("rnd_rise", rise, m_rise);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
